// File: rtl/five_bit_display_sched.sv
// Round-robin scheduler that shares one 5-bit to 3-digit 7-seg decoder between sources.
// Optional src_led one-hot output when SCHED_SRC_LED_EN is defined.
module five_bit_display_sched #(
  parameter int NUM_SRC      = 4,
  parameter int DWELL_CYCLES = 16,
  parameter int SCAN_DIV     = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [5*NUM_SRC-1:0]   src_vals,
  input  logic [NUM_SRC-1:0]     src_valid,
  input  logic                   hold,
  input  logic                   next_req,
  output logic [4:0]             sel_bits,
  output logic [1:0]             sel_idx,
  input  logic [20:0]            display_in,
  output logic [6:0]             seg_out,
  output logic [2:0]             digit_en
`ifdef SCHED_SRC_LED_EN
  ,
  output logic [NUM_SRC-1:0]     src_led
`endif
);

  localparam int DW_W = $clog2(DWELL_CYCLES);
  localparam int SD_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW_W-1:0] DW_MAX = DW_W'(DWELL_CYCLES - 1);
  localparam logic [SD_W-1:0] SD_MAX = SD_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHOW,
    ST_HOLD
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        sel_idx_q, sel_idx_d;
  logic [4:0]        sel_bits_q, sel_bits_d;
  logic [DW_W-1:0]   dwell_q, dwell_d;
  logic [SD_W-1:0]   div_q, div_d;
  logic [1:0]        digit_q, digit_d;
  logic [6:0]        seg_q, seg_d;
  logic [2:0]        den_q, den_d;

  logic [1:0]        lo_idx;
  logic [1:0]        nxt_idx;
  logic              nxt_found;
  logic              advance;
  logic [6:0]        digit_pat;

  // lowest valid index, and the next valid one above sel_idx (wrapping to itself)
  always_comb begin
    lo_idx    = '0;
    nxt_idx   = sel_idx_q;
    nxt_found = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (src_valid[i]) lo_idx = 2'(i);
    end
    for (int k = 1; k <= NUM_SRC; k++) begin
      if (!nxt_found && src_valid[(int'(sel_idx_q) + k) % NUM_SRC]) begin
        nxt_found = 1'b1;
        nxt_idx   = 2'((int'(sel_idx_q) + k) % NUM_SRC);
      end
    end
  end

  always_comb begin
    case (digit_q)
      2'd0:    digit_pat = display_in[6:0];
      2'd1:    digit_pat = display_in[13:7];
      default: digit_pat = display_in[20:14];
    endcase
  end

  always_comb begin
    state_d    = state_q;
    sel_idx_d  = sel_idx_q;
    sel_bits_d = sel_bits_q;
    dwell_d    = dwell_q;
    div_d      = div_q;
    digit_d    = digit_q;
    seg_d      = seg_q;
    den_d      = den_q;
    advance    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (|src_valid) begin
          state_d    = ST_SHOW;
          sel_idx_d  = lo_idx;
          sel_bits_d = src_vals[5*int'(lo_idx) +: 5];
          dwell_d    = '0;
          div_d      = '0;
          digit_d    = '0;
        end
      end
      ST_SHOW, ST_HOLD: begin
        if (src_valid == '0) begin
          state_d    = ST_IDLE;
          sel_bits_d = '0;
          seg_d      = '0;
          den_d      = '0;
          dwell_d    = '0;
          div_d      = '0;
          digit_d    = '0;
        end else begin
          state_d = hold ? ST_HOLD : ST_SHOW;
          advance = next_req || !src_valid[sel_idx_q] ||
                    (state_q == ST_SHOW && dwell_q == DW_MAX);
          if (advance) begin
            sel_idx_d  = nxt_idx;
            sel_bits_d = src_vals[5*int'(nxt_idx) +: 5];
            dwell_d    = '0;
          end else if (state_q == ST_SHOW) begin
            dwell_d = dwell_q + 1'b1;
          end
          seg_d = digit_pat;
          den_d = 3'b001 << digit_q;
          if (div_q == SD_MAX) begin
            div_d   = '0;
            digit_d = (digit_q == 2'd2) ? 2'd0 : digit_q + 2'd1;
          end else begin
            div_d = div_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      sel_idx_q  <= '0;
      sel_bits_q <= '0;
      dwell_q    <= '0;
      div_q      <= '0;
      digit_q    <= '0;
      seg_q      <= '0;
      den_q      <= '0;
    end else begin
      state_q    <= state_d;
      sel_idx_q  <= sel_idx_d;
      sel_bits_q <= sel_bits_d;
      dwell_q    <= dwell_d;
      div_q      <= div_d;
      digit_q    <= digit_d;
      seg_q      <= seg_d;
      den_q      <= den_d;
    end
  end

  assign sel_bits = sel_bits_q;
  assign sel_idx  = sel_idx_q;
  assign seg_out  = seg_q;
  assign digit_en = den_q;

`ifdef SCHED_SRC_LED_EN
  logic [NUM_SRC-1:0] src_led_q, src_led_d;

  always_comb begin
    src_led_d = '0;
    if (state_d != ST_IDLE) src_led_d = NUM_SRC'(1) << sel_idx_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) src_led_q <= '0;
    else          src_led_q <= src_led_d;
  end

  assign src_led = src_led_q;
`endif

endmodule

// File: tb/tb_five_bit_display_sched.sv
// Bench for five_bit_display_sched: directed sequences, a scan table and
// randomized traffic against a behavioural model.
module tb_five_bit_display_sched;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [19:0] src_vals;
  logic [3:0]  src_valid;
  logic        hold;
  logic        next_req;
  logic [4:0]  sel_bits;
  logic [1:0]  sel_idx;
  logic [20:0] display_in;
  logic [6:0]  seg_out;
  logic [2:0]  digit_en;
`ifdef SCHED_SRC_LED_EN
  logic [3:0]  src_led;
`endif

  always #5 clk = ~clk;

  five_bit_display_sched #(
    .NUM_SRC(N), .DWELL_CYCLES(DW), .SCAN_DIV(SD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .src_vals(src_vals),
    .src_valid(src_valid), .hold(hold), .next_req(next_req),
    .sel_bits(sel_bits), .sel_idx(sel_idx), .display_in(display_in),
    .seg_out(seg_out), .digit_en(digit_en)
`ifdef SCHED_SRC_LED_EN
    , .src_led(src_led)
`endif
  );

  int checks = 0;
  int errors = 0;

  // behavioural model: which source is on screen and for how long
  bit         m_act;
  bit         m_held;
  int         m_cur;
  int         m_shown;
  int         m_scan;
  logic [4:0] m_bits;
  logic [2:0] m_den;
  logic [6:0] m_seg;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int  d;
    bit  adv;
    bit  found;
    if (!reset_n) begin
      m_act = 0; m_held = 0; m_cur = 0; m_shown = 0; m_scan = 0;
      m_bits = 0; m_den = 0; m_seg = 0;
    end else if (!m_act) begin
      if (src_valid != 0) begin
        found = 0;
        for (int i = 0; i < N; i++) begin
          if (!found && src_valid[i]) begin
            found = 1; m_cur = i;
          end
        end
        m_act = 1; m_held = 0; m_shown = 0; m_scan = 0;
        m_bits = src_vals[5*m_cur +: 5];
      end
    end else if (src_valid == 0) begin
      m_act = 0; m_bits = 0; m_den = 0; m_seg = 0;
    end else begin
      d = (m_scan / SD) % 3;
      m_den = 3'(1 << d);
      m_seg = display_in[7*d +: 7];
      m_scan++;
      adv = next_req || !src_valid[m_cur] || (!m_held && m_shown == DW - 1);
      if (adv) begin
        found = 0;
        for (int k = 1; k <= N; k++) begin
          if (!found && src_valid[(m_cur + k) % N]) begin
            found = 1; m_cur = (m_cur + k) % N;
          end
        end
        m_bits = src_vals[5*m_cur +: 5];
        m_shown = 0;
      end else if (!m_held) begin
        m_shown++;
      end
      m_held = hold;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("m_sel_bits", sel_bits, m_bits);
    chk("m_sel_idx", sel_idx, m_cur[1:0]);
    chk("m_digit_en", digit_en, m_den);
    chk("m_seg_out", seg_out, m_seg);
`ifdef SCHED_SRC_LED_EN
    chk("m_src_led", src_led, m_act ? 32'(1 << m_cur) : 32'd0);
`endif
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  typedef struct {
    int         cycles;
    logic [2:0] den;
    logic [6:0] seg;
  } scan_vec_t;

  scan_vec_t scan_tab[5];
  int        seq1[4];
  int        idx2[3];
  int        bits2[3];

  initial begin
    scan_tab[0] = '{1, 3'b000, 7'h00};
    scan_tab[1] = '{4, 3'b001, 7'h5E};
    scan_tab[2] = '{4, 3'b010, 7'h79};
    scan_tab[3] = '{4, 3'b100, 7'h6A};
    scan_tab[4] = '{4, 3'b001, 7'h5E};
    seq1  = '{3, 5, 7, 9};
    idx2  = '{1, 3, 1};
    bits2 = '{21, 4, 21};

    reset_n = 1'b0; src_vals = '0; src_valid = '0;
    hold = 1'b0; next_req = 1'b0; display_in = '0;
    step();
    step();
    chk("rst_sel_bits", sel_bits, 0);
    chk("rst_sel_idx", sel_idx, 0);
    chk("rst_seg_out", seg_out, 0);
    chk("rst_digit_en", digit_en, 0);

    // round robin over all four sources
    reset_n = 1'b1;
    src_vals = {5'd9, 5'd7, 5'd5, 5'd3};
    src_valid = 4'b1111;
    display_in = 21'h1ABCDE;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 16; c++) begin
        step();
        chk("t1_bits", sel_bits, seq1[k]);
      end
    end
    step();
    chk("t1_wrap", sel_bits, 3);

    // sparse valid mask skips indices 0 and 2
    src_valid = 4'b0000;
    step();
    chk("t2_idle_bits", sel_bits, 0);
    src_vals = {5'd4, 5'd30, 5'd21, 5'd17};
    src_valid = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 16; c++) begin
        step();
        chk("t2_idx", sel_idx, idx2[k]);
        chk("t2_bits", sel_bits, bits2[k]);
      end
    end

    // hold freezes dwell, which resumes on release
    src_vals = {5'd9, 5'd7, 5'd5, 5'd3};
    src_valid = 4'b1111;
    do_reset();
    step();
    repeat (5) step();
    hold = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step();
      chk("t3_held", sel_bits, 3);
    end
    hold = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("t3_resume", sel_bits, 3);
    end
    step();
    chk("t3_switch", sel_bits, 5);

    // next_req while held advances and stays held
    do_reset();
    step();
    repeat (3) step();
    hold = 1'b1;
    repeat (3) step();
    next_req = 1'b1;
    step();
    next_req = 1'b0;
    chk("t3_nreq_idx", sel_idx, 1);
    chk("t3_nreq_bits", sel_bits, 5);
    for (int c = 0; c < 30; c++) begin
      step();
      chk("t3_nreq_stay", sel_idx, 1);
    end
    hold = 1'b0;
    step();

    // current source drops its request, in SHOW then in HOLD
    src_valid = 4'b1101;
    step();
    chk("t4_drop_idx", sel_idx, 2);
    chk("t4_drop_bits", sel_bits, 7);
    hold = 1'b1;
    repeat (2) step();
    src_valid = 4'b1001;
    step();
    chk("t4_hdrop_idx", sel_idx, 3);
    chk("t4_hdrop_bits", sel_bits, 9);
    hold = 1'b0;
    src_valid = 4'b0000;
    step();
    chk("t4_idle_bits", sel_bits, 0);
    chk("t4_idle_den", digit_en, 0);

    // digit scan order and slices
    do_reset();
    display_in = 21'h1ABCDE;
    src_valid = 4'b0001;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < scan_tab[r].cycles; c++) begin
        step();
        chk("t5_den", digit_en, scan_tab[r].den);
        chk("t5_seg", seg_out, scan_tab[r].seg);
      end
    end

    // reset in the middle of a scan frame
    step();
    reset_n = 1'b0;
    step();
    chk("t6_bits", sel_bits, 0);
    chk("t6_idx", sel_idx, 0);
    chk("t6_den", digit_en, 0);
    chk("t6_seg", seg_out, 0);
`ifdef SCHED_SRC_LED_EN
    chk("t6_led_rst", src_led, 0);
`endif
    reset_n = 1'b1;
    src_valid = 4'b0100;
    step();
    chk("t6_idx2", sel_idx, 2);
`ifdef SCHED_SRC_LED_EN
    chk("t6_led", src_led, 4'b0100);
`endif

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) src_valid = 4'($urandom);
      if ($urandom_range(0, 29) == 0) hold = ~hold;
      if ($urandom_range(0, 49) == 0) src_vals = 20'($urandom);
      next_req = ($urandom_range(0, 15) == 0);
      display_in = 21'($urandom);
      reset_n = ($urandom_range(0, 499) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
